// File: rtl/imm_gen_if.sv
// imm_gen_if: decode-side and execute-side handshake for imm_gen_pipe.
// master = the surrounding pipeline (drives instr/src/in_valid, out_ready),
// slave  = imm_gen_pipe.
// out_err exists only when IMMGEN_ERR_EN is defined.
interface imm_gen_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [2:0]      src;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imm;
`ifdef IMMGEN_ERR_EN
   logic            out_err;
`endif

   modport master (
      output in_valid, instr, src, out_ready,
      input  in_ready, out_valid, imm
`ifdef IMMGEN_ERR_EN
      , input out_err
`endif
   );

   modport slave (
      input  in_valid, instr, src, out_ready,
      output in_ready, out_valid, imm
`ifdef IMMGEN_ERR_EN
      , output out_err
`endif
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator, XLEN = 32 or 64.
// One output register (OR) plus one skid register (SK); in_ready is a pure
// function of registered state, so there is no path from out_ready to in_ready.
// Optional feature macro: IMMGEN_ERR_EN adds out_err, flagging src = 3'b111.
//
// state | meaning
// EMPTY | OR empty, SK empty
// ONE   | OR holds an entry, SK empty
// FULL  | OR and SK both hold entries, in_ready low
module imm_gen_pipe #(
   parameter int XLEN = 32
) (
   input logic     clk,
   input logic     rst_n,
   imm_gen_if.slave bus
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t          state_q, state_d;
   logic            accept, emit;
   logic            ld_or_new, ld_or_sk, ld_sk;
   logic            sgn;
   logic [XLEN-1:0] imm_d, or_imm, sk_imm;
   logic            unused_opcode;
`ifdef IMMGEN_ERR_EN
   logic            err_d, or_err, sk_err;
`endif

   assign sgn           = bus.instr[31];
   assign unused_opcode = &{1'b0, bus.instr[6:0]};

   assign bus.in_ready  = (state_q != FULL);
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.imm       = or_imm;
`ifdef IMMGEN_ERR_EN
   assign bus.out_err   = or_err;
`endif

   assign accept = bus.in_valid && bus.in_ready;
   assign emit   = bus.out_valid && bus.out_ready;

   // Immediate decode from the format select.
   always_comb begin
      imm_d = '0;
`ifdef IMMGEN_ERR_EN
      err_d = 1'b0;
`endif
      case (bus.src)
         3'b000: imm_d = {{(XLEN-12){sgn}}, bus.instr[31:20]};
         3'b001: imm_d = {{(XLEN-12){sgn}}, bus.instr[31:25], bus.instr[11:7]};
         3'b010: imm_d = {{(XLEN-12){sgn}}, bus.instr[7], bus.instr[30:25],
                          bus.instr[11:8], 1'b0};
         3'b011: imm_d = {{(XLEN-20){sgn}}, bus.instr[19:12], bus.instr[20],
                          bus.instr[30:21], 1'b0};
         3'b100: imm_d = {{(XLEN-31){sgn}}, bus.instr[30:12], 12'b0};
         3'b101: imm_d = {{(XLEN-5){1'b0}}, bus.instr[19:15]};
         3'b110: begin
            if (XLEN == 64) imm_d = {{(XLEN-6){1'b0}}, bus.instr[25:20]};
            else            imm_d = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
         end
         default: begin
            imm_d = '0;
`ifdef IMMGEN_ERR_EN
            err_d = 1'b1;
`endif
         end
      endcase
   end

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Next occupancy and register load strobes.
   always_comb begin
      state_d   = state_q;
      ld_or_new = 1'b0;
      ld_or_sk  = 1'b0;
      ld_sk     = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               ld_or_new = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (accept && emit) begin
               ld_or_new = 1'b1;
            end else if (accept) begin
               ld_sk   = 1'b1;
               state_d = FULL;
            end else if (emit) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // accept cannot happen here: in_ready is low
            if (emit) begin
               ld_or_sk = 1'b1;
               state_d  = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // OR and SK data registers; OR holds its value while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         or_imm <= '0;
         sk_imm <= '0;
`ifdef IMMGEN_ERR_EN
         or_err <= 1'b0;
         sk_err <= 1'b0;
`endif
      end else begin
         if (ld_or_new) begin
            or_imm <= imm_d;
`ifdef IMMGEN_ERR_EN
            or_err <= err_d;
`endif
         end else if (ld_or_sk) begin
            or_imm <= sk_imm;
`ifdef IMMGEN_ERR_EN
            or_err <= sk_err;
`endif
         end
         if (ld_sk) begin
            sk_imm <= imm_d;
`ifdef IMMGEN_ERR_EN
            sk_err <= err_d;
`endif
         end
      end
   end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RISC-V decode stage. Takes a 32-bit instruction word and a format select, then produces the sign- or zero-extended immediate at data-path width XLEN. A valid/ready handshake on both sides and an internal skid register decouple decode from the execute stage. Sits between the instruction register and the ALU operand mux, and replaces the fixed 32-bit, four-format extender.

## Interface
- XLEN, 32: output width; legal values 32 or 64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instr/src valid.
- in_ready  out  1  block can accept; registered (no combinational path from out_ready).
- instr  in  32  instruction word.
- src  in  3  format select (see Operation).
- out_valid  out  1  imm valid.
- out_ready  in  1  consumer accepts.
- imm  out  XLEN  extended immediate.
- out_err  out  1  illegal src flag; present only with IMMGEN_ERR_EN.

## Operation
- Format select; S = instr[31] replicated to XLEN:
  - 000 I: S, instr[31:20].
  - 001 S: S, instr[31:25], instr[11:7].
  - 010 B: S, instr[7], instr[30:25], instr[11:8], 0.
  - 011 J: S, instr[19:12], instr[20], instr[30:21], 0.
  - 100 U: S, instr[31:12], 12'b0. Upper bits are sign-extended when XLEN=64.
  - 101 Z: zero-extended instr[19:15] (CSR uimm).
  - 110 SH: zero-extended shamt. instr[25:20] when XLEN=64; instr[24:20] when XLEN=32.
  - 111: illegal. imm = 0.
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Storage: output register (OR) plus one skid register (SK). Entries leave in acceptance order.
- Accept with OR empty, or with OR emitting that cycle and SK empty: result loads OR.
- Accept with OR full and not emitting: result loads SK. in_ready drops next cycle.
- Emit with SK full: SK moves to OR. SK clears. in_ready rises next cycle.
- Occupancy states: EMPTY (OR-, SK-), ONE (OR+, SK-), FULL (OR+, SK+).
- in_ready = !SK_full.
- imm, and out_err when present, are held stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle from accept to out_valid when the block is empty.
- Throughput: 1 per cycle with out_ready held high.
- Reset (async assert, sync release) forces: out_valid=0, imm=0, out_err=0, in_ready=1, SK empty.
- Reset asserted mid-transfer discards both entries. No emit occurs in that cycle.
- Simultaneous accept and emit in ONE: OR reloads with the new result. State stays ONE.
- Simultaneous accept and emit in FULL: cannot occur, because in_ready=0.
- in_valid while in_ready=0: ignored. The producer must hold its data.
- src/instr are sampled only on accept. Inputs are don't-care otherwise.

## Configuration
- IMMGEN_ERR_EN defined: out_err port exists. It is set with the entry when src=111 and travels with that entry through OR/SK. imm=0 for that entry.
- IMMGEN_ERR_EN undefined: no out_err port. src=111 yields imm=0 silently.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, imm=0, in_ready=1.
- Formats, XLEN=32, out_ready=1:
  - I 0xFFF00093 -> 0xFFFFFFFF.
  - S 0xFE20AE23 -> 0xFFFFFFFC.
  - B 0xFE000CE3 -> 0xFFFFFFF8.
  - U 0x123452B7 -> 0x12345000.
  - Each result appears 1 cycle after accept.
- XLEN=64:
  - U 0x800002B7 -> 0xFFFFFFFF80000000.
  - SH with instr[25:20]=0x3F -> 0x000000000000003F.
  - Z with instr[19:15]=0x1F -> 0x1F.
- Backpressure: out_ready=0 while sending I 0x00100093 then I 0x00200093.
  - Expect in_ready=0 after the second accept, and imm held at 1.
  - Raise out_ready -> outputs 1 then 2, in order. in_ready returns to 1.
- Streaming: 16 back-to-back accepts with out_ready=1 -> 16 outputs on consecutive cycles, in_ready never low.
- Illegal src=111 with IMMGEN_ERR_EN defined -> imm=0, out_err=1 for exactly that entry only.
- Async reset asserted in FULL -> outputs drop to reset values immediately, with no clock edge required.
